cpu: RTL and testbench
======================

Name: cpu

Overview:
- Multicycle 16-bit CPU datapath (no internal control unit).
- Holds IR, PC, an 8×16 register file, two operand buffers, the ALU output register and the status register.
- Every register write enable and mux select comes from an external control unit. The datapath returns `opcode` and `status_reg` to that unit.
- Memory is external: the datapath drives address and write data, and receives read data on `memory_in`.

Parameters:
- WORD_SIZE, 16, datapath/memory word width.
- ALU_OP_SIZE, 3, ALU operation select width.
- REG_ADDR_SIZE, 3, register address width (8 registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ALU_in2_mux  in  1  ALU B operand: 0 = sext(IR[10:6]), 1 = buff2.
- mem_out_mux  in  1  memory_out source: 0 = buff1, 1 = PC.
- PC_mux  in  2  PC next value: 0 = PC+1, 1 = ALU_out, 2 = sext(IR[10:3]), 3 = buff1.
- memory_addr_mux  in  2  memory_addr source: 0 = PC, 1 = ALU_out, 2 = zext(IR[10:3]), 3 = buff2.
- data_in_mux  in  2  register-file write data: 0 = ALU_out, 1 = memory_in, 2 = zext(IR[10:3]), 3 = PC.
- reg_buff1_write  in  1  load buff1.
- reg_buff2_write  in  1  load buff2.
- status_reg_write  in  1  load flags.
- ALU_out_write  in  1  load ALU_out.
- reg_write  in  1  write reg[IR[2:0]].
- PC_write  in  1  load PC.
- IR_write  in  1  load IR from memory_in.
- memory_in  in  16  memory read data / instruction.
- memory_addr  out  16  memory address (combinational).
- memory_out  out  16  memory write data (combinational).
- opcode  out  5  IR[15:11].
- status_reg  out  16  flag register.

Behaviour:
- Reset: on a rising edge with rst=1, IR, PC, buff1, buff2, ALU_out, status_reg and all 8 registers clear to 0. Reset overrides every write enable.

Instruction fields:
- opcode = IR[15:11]; rd = IR[2:0]; rs1 = IR[5:3]; rs2 = IR[8:6].
- imm8 = IR[10:3]; imm5 = IR[10:6].
- Register file write address is always rd.

Operand buffers:
- buff1 read address = rd when opcode[4:3] = 2'b11 (immediate/memory class, e.g. load_i 11110, store 11101); otherwise rs1.
- buff2 read address = rs2.
- Buffers capture register-file contents as they stood before the edge. A simultaneous reg_write does not bypass into them.

ALU:
- Combinational, A = buff1, B = per ALU_in2_mux, op = opcode[2:0].
- Ops: 000 add, 001 sub (A−B), 010 and, 011 or, 100 xor, 101 not A, 110 A<<B[3:0], 111 A>>B[3:0] (logical).
- 16-bit result, wrap-around modulo 2^16.

Flags (combinational, latched into status_reg on status_reg_write):
- bit0 Z = result==0.
- bit1 N = result[15].
- bit2 C = carry out for add, no-borrow for sub, 0 otherwise.
- bit3 V = signed overflow for add/sub, 0 otherwise.
- bits[15:4] = 0.

Registered loads: ALU_out loads the combinational ALU result on ALU_out_write; PC loads the PC_mux selection on PC_write; IR loads memory_in on IR_write.

Timing and concurrency:
- All write enables are independent; any combination may be asserted in one cycle, and each register updates from pre-edge values.
- Latency: buffers → ALU_out is one cycle. The IR-dependent outputs (opcode, immediate paths, memory_addr with mux=2) are valid the cycle after IR_write.
- A register with its enable low holds its value.
- r0 is an ordinary writable register.

Test Plan:
- Reset: assert rst for one edge → all outputs and registers 0, opcode=0, status_reg=0, memory_addr=0 (mux 0).
- load_i: IR←16'hF059 (opcode 11110, imm8=11, rd=1), then data_in_mux=2, reg_write=1 → r1=11. Repeat with 16'hF023 → r3=4.
- store: IR←16'hE811, reg_buff1_write=1 → buff1=11; memory_addr_mux=2 → memory_addr=2; mem_out_mux=0 → memory_out=11. Same with 16'hE813 → memory_out=4.
- add: IR←16'h00C8 (rd=0, rs1=1, rs2=3), reg_buff1_write=reg_buff2_write=1, ALU_in2_mux=1, then ALU_out_write=1 → ALU_out=15. Then data_in_mux=0, reg_write=1 → r0=15.
- Flags: sub with buff1=buff2=5 and status_reg_write → Z=1, C=1. Add 16'h7FFF+1 → N=1, V=1, Z=0.
- PC: PC_mux=0, PC_write for 3 cycles → PC=3, memory_addr=3 (mux 0). Assert rst in the same cycle as PC_write → PC=0.

Source files
------------

// File: rtl/cpu.sv
// Multicycle 16-bit CPU datapath: IR, PC, 8x16 register file, operand buffers,
// ALU output and status registers. All enables and selects come from an external control unit.
module cpu #(
  parameter int WORD_SIZE     = 16,
  parameter int ALU_OP_SIZE   = 3,
  parameter int REG_ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ALU_in2_mux,
  input  logic                 mem_out_mux,
  input  logic [1:0]           PC_mux,
  input  logic [1:0]           memory_addr_mux,
  input  logic [1:0]           data_in_mux,
  input  logic                 reg_buff1_write,
  input  logic                 reg_buff2_write,
  input  logic                 status_reg_write,
  input  logic                 ALU_out_write,
  input  logic                 reg_write,
  input  logic                 PC_write,
  input  logic                 IR_write,
  input  logic [WORD_SIZE-1:0] memory_in,
  output logic [WORD_SIZE-1:0] memory_addr,
  output logic [WORD_SIZE-1:0] memory_out,
  output logic [4:0]           opcode,
  output logic [WORD_SIZE-1:0] status_reg
);

  localparam int NUM_REGS = 2 ** REG_ADDR_SIZE;

  logic [WORD_SIZE-1:0] ir_q, pc_q, buff1_q, buff2_q, alu_out_q, status_q;
  logic [WORD_SIZE-1:0] rf_q [NUM_REGS];

  logic [WORD_SIZE-1:0] pc_d, rf_wdata_d, status_d;
  logic [WORD_SIZE-1:0] alu_a, alu_b, alu_res;
  logic [WORD_SIZE:0]   sum_w;
  logic                 alu_c, alu_v;
  logic [REG_ADDR_SIZE-1:0] rd, rs1, rs2, buff1_addr;
  logic [ALU_OP_SIZE-1:0]   alu_op;
  logic [7:0]           imm8;
  logic [4:0]           imm5;
  logic [WORD_SIZE-1:0] imm8_sext, imm8_zext, imm5_sext;

  assign opcode    = ir_q[15:11];
  assign rd        = ir_q[2:0];
  assign rs1       = ir_q[5:3];
  assign rs2       = ir_q[8:6];
  assign imm8      = ir_q[10:3];
  assign imm5      = ir_q[10:6];
  assign alu_op    = opcode[ALU_OP_SIZE-1:0];
  assign imm8_sext = {{(WORD_SIZE-8){imm8[7]}}, imm8};
  assign imm8_zext = {{(WORD_SIZE-8){1'b0}}, imm8};
  assign imm5_sext = {{(WORD_SIZE-5){imm5[4]}}, imm5};

  // Immediate/memory-class instructions use rd as the source of buff1 (e.g. store data)
  assign buff1_addr = (opcode[4:3] == 2'b11) ? rd : rs1;
  assign status_reg = status_q;

  always_comb begin
    alu_a   = buff1_q;
    alu_b   = ALU_in2_mux ? buff2_q : imm5_sext;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = '0;
    case (alu_op)
      3'd0: begin
        sum_w   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = sum_w[WORD_SIZE-1:0];
        alu_c   = sum_w[WORD_SIZE];
        alu_v   = (alu_a[WORD_SIZE-1] == alu_b[WORD_SIZE-1]) &&
                  (alu_res[WORD_SIZE-1] != alu_a[WORD_SIZE-1]);
      end
      3'd1: begin
        // A + ~B + 1: carry out is the no-borrow flag
        sum_w   = {1'b0, alu_a} + {1'b0, ~alu_b} + (WORD_SIZE+1)'(1);
        alu_res = sum_w[WORD_SIZE-1:0];
        alu_c   = sum_w[WORD_SIZE];
        alu_v   = (alu_a[WORD_SIZE-1] != alu_b[WORD_SIZE-1]) &&
                  (alu_res[WORD_SIZE-1] != alu_a[WORD_SIZE-1]);
      end
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = alu_a | alu_b;
      3'd4:    alu_res = alu_a ^ alu_b;
      3'd5:    alu_res = ~alu_a;
      3'd6:    alu_res = alu_a << alu_b[3:0];
      default: alu_res = alu_a >> alu_b[3:0];
    endcase
    status_d      = '0;
    status_d[3:0] = {alu_v, alu_c, alu_res[WORD_SIZE-1], alu_res == '0};
  end

  always_comb begin
    case (PC_mux)
      2'd0:    pc_d = pc_q + WORD_SIZE'(1);
      2'd1:    pc_d = alu_out_q;
      2'd2:    pc_d = imm8_sext;
      default: pc_d = buff1_q;
    endcase
    case (memory_addr_mux)
      2'd0:    memory_addr = pc_q;
      2'd1:    memory_addr = alu_out_q;
      2'd2:    memory_addr = imm8_zext;
      default: memory_addr = buff2_q;
    endcase
    case (data_in_mux)
      2'd0:    rf_wdata_d = alu_out_q;
      2'd1:    rf_wdata_d = memory_in;
      2'd2:    rf_wdata_d = imm8_zext;
      default: rf_wdata_d = pc_q;
    endcase
    memory_out = mem_out_mux ? pc_q : buff1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= '0;
      pc_q      <= '0;
      buff1_q   <= '0;
      buff2_q   <= '0;
      alu_out_q <= '0;
      status_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      if (IR_write)         ir_q      <= memory_in;
      if (PC_write)         pc_q      <= pc_d;
      if (reg_buff1_write)  buff1_q   <= rf_q[buff1_addr];
      if (reg_buff2_write)  buff2_q   <= rf_q[rs2];
      if (ALU_out_write)    alu_out_q <= alu_res;
      if (status_reg_write) status_q  <= status_d;
      if (reg_write)        rf_q[rd]  <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the cpu datapath: drives control words and checks
// observable outputs against hand-computed values.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ALU_in2_mux, mem_out_mux;
  logic [1:0]  PC_mux, memory_addr_mux, data_in_mux;
  logic        reg_buff1_write, reg_buff2_write, status_reg_write;
  logic        ALU_out_write, reg_write, PC_write, IR_write;
  logic [15:0] memory_in;
  logic [15:0] memory_addr, memory_out, status_reg;
  logic [4:0]  opcode;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu dut (
    .clk(clk), .rst(rst),
    .ALU_in2_mux(ALU_in2_mux), .mem_out_mux(mem_out_mux),
    .PC_mux(PC_mux), .memory_addr_mux(memory_addr_mux), .data_in_mux(data_in_mux),
    .reg_buff1_write(reg_buff1_write), .reg_buff2_write(reg_buff2_write),
    .status_reg_write(status_reg_write), .ALU_out_write(ALU_out_write),
    .reg_write(reg_write), .PC_write(PC_write), .IR_write(IR_write),
    .memory_in(memory_in), .memory_addr(memory_addr), .memory_out(memory_out),
    .opcode(opcode), .status_reg(status_reg)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; ALU_in2_mux = 0; mem_out_mux = 0; PC_mux = 0; memory_addr_mux = 0;
    data_in_mux = 0; reg_buff1_write = 0; reg_buff2_write = 0; status_reg_write = 0;
    ALU_out_write = 0; reg_write = 0; PC_write = 0; IR_write = 0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    memory_in = v; IR_write = 1; tick(); IR_write = 0;
  endtask

  task automatic wr_reg(input logic [1:0] sel);
    data_in_mux = sel; reg_write = 1; tick(); reg_write = 0;
  endtask

  task automatic load_bufs();
    reg_buff1_write = 1; reg_buff2_write = 1; tick();
    reg_buff1_write = 0; reg_buff2_write = 0;
  endtask

  task automatic alu_step();
    ALU_out_write = 1; status_reg_write = 1; tick();
    ALU_out_write = 0; status_reg_write = 0;
  endtask

  // buff1 = 7FFF, B = imm5 = 1 (or -1 for the sub entry)
  logic [15:0] t_ir  [8] = '{16'h0060, 16'h3060, 16'h3860, 16'h2860,
                             16'h0FE0, 16'h1060, 16'h2060, 16'h1860};
  logic [15:0] t_res [8] = '{16'h8000, 16'hFFFE, 16'h3FFF, 16'h8000,
                             16'h8000, 16'h0001, 16'h7FFE, 16'h7FFF};
  logic [15:0] t_st  [8] = '{16'h000A, 16'h0002, 16'h0000, 16'h0002,
                             16'h000A, 16'h0000, 16'h0000, 16'h0000};

  initial begin
    idle();
    memory_in = 16'hA5A5;
    rst = 1; tick(); rst = 0;
    chk("rst_pc",     memory_addr, 16'h0000);
    chk("rst_opcode", {11'd0, opcode}, 16'h0000);
    chk("rst_status", status_reg, 16'h0000);
    chk("rst_buff1",  memory_out, 16'h0000);
    memory_addr_mux = 1; #1 chk("rst_aluout", memory_addr, 16'h0000);
    memory_addr_mux = 3; #1 chk("rst_buff2",  memory_addr, 16'h0000);
    memory_addr_mux = 0;

    // load_i r1 = 11, r3 = 4
    load_ir(16'hF059);
    chk("opcode_loadi", {11'd0, opcode}, 16'h001E);
    wr_reg(2);
    load_ir(16'hF023);
    memory_addr_mux = 2; #1 chk("imm8_zext", memory_addr, 16'h0004);
    wr_reg(2);

    // store reads rd into buff1
    load_ir(16'hE811);
    chk("opcode_store", {11'd0, opcode}, 16'h001D);
    reg_buff1_write = 1; tick(); reg_buff1_write = 0;
    chk("store_r1_data", memory_out, 16'd11);
    chk("store_addr", memory_addr, 16'd2);
    load_ir(16'hE813);
    reg_buff1_write = 1; tick(); reg_buff1_write = 0;
    chk("store_r3_data", memory_out, 16'd4);

    // add r0 = r1 + r3
    load_ir(16'h00C8);
    load_bufs();
    memory_addr_mux = 3; #1 chk("buff2_r3", memory_addr, 16'd4);
    ALU_in2_mux = 1; ALU_out_write = 1; tick(); ALU_out_write = 0;
    memory_addr_mux = 1; #1 chk("add_aluout", memory_addr, 16'd15);
    wr_reg(0);
    load_ir(16'hE810);
    reg_buff1_write = 1; tick(); reg_buff1_write = 0;
    chk("r0_written", memory_out, 16'd15);

    // sub 5 - 5 -> Z and C
    load_ir(16'hF02A);
    wr_reg(2);
    load_ir(16'h0890);
    load_bufs();
    ALU_in2_mux = 1; alu_step();
    chk("sub_eq_flags", status_reg, 16'h0005);
    chk("sub_eq_res", memory_addr, 16'h0000);

    // r4 = 7FFF from memory_in, then op table with immediate B
    load_ir(16'h0004);
    memory_in = 16'h7FFF; wr_reg(1);
    load_ir(16'h0060);
    reg_buff1_write = 1; tick(); reg_buff1_write = 0;
    ALU_in2_mux = 0;
    for (int i = 0; i < 8; i++) begin
      load_ir(t_ir[i]);
      alu_step();
      chk($sformatf("op%0d_res", i), memory_addr, t_res[i]);
      chk($sformatf("op%0d_flags", i), status_reg, t_st[i]);
    end

    // status holds when its enable is low
    load_ir(16'h0FE0);
    ALU_out_write = 1; tick(); ALU_out_write = 0;
    chk("status_hold", status_reg, 16'h0000);

    // PC increment, sign-extended immediate, wrap, reset priority
    memory_addr_mux = 0; PC_mux = 0; PC_write = 1;
    tick(); tick(); tick(); PC_write = 0;
    chk("pc_inc3", memory_addr, 16'd3);
    mem_out_mux = 1; #1 chk("pc_memout", memory_out, 16'd3);
    data_in_mux = 3; load_ir(16'h0005); wr_reg(3);
    load_ir(16'h07F8);
    PC_mux = 2; PC_write = 1; tick(); PC_write = 0;
    chk("pc_sext", memory_addr, 16'hFFFF);
    PC_mux = 0; PC_write = 1; tick(); PC_write = 0;
    chk("pc_wrap", memory_addr, 16'h0000);
    PC_write = 1; tick(); PC_write = 0;
    chk("pc_one", memory_addr, 16'h0001);
    load_ir(16'hE815);
    mem_out_mux = 0; reg_buff1_write = 1; tick(); reg_buff1_write = 0;
    chk("r5_from_pc", memory_out, 16'd3);
    PC_write = 1; rst = 1; tick(); PC_write = 0; rst = 0;
    chk("pc_rst_prio", memory_addr, 16'h0000);
    chk("rst_status2", status_reg, 16'h0000);
    chk("rst_opcode2", {11'd0, opcode}, 16'h0000);
    chk("rst_buff1_2", memory_out, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
